// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci term controller: default widths and FSM encoding.
package fib_pkg;

    localparam int unsigned WIDTH_DEF = 10;
    localparam int unsigned NW_DEF    = 6;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/fib_term_ctrl_if.sv
// Request/response bus of the Fibonacci term controller.
// slave = controller side, master = requester/consumer side.
interface fib_term_ctrl_if
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NW    = NW_DEF
);
    logic             req_valid;
    logic             req_ready;
    logic [NW-1:0]    req_n;
    logic             abort;
    logic             busy;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_value;
    logic             resp_ovf;

    modport slave (
        input  req_valid, req_n, abort, resp_ready,
        output req_ready, busy, resp_valid, resp_value, resp_ovf
    );

    modport master (
        output req_valid, req_n, abort, resp_ready,
        input  req_ready, busy, resp_valid, resp_value, resp_ovf
    );
endinterface

// File: rtl/fib_step.sv
// Fibonacci step datapath: holds the (a, b) pair and its sticky overflow flags.
// Optional macro FIB_CTRL_SAT_EN: saturate b to all-ones once the sequence overflows;
// otherwise values wrap modulo 2^WIDTH.
module fib_step
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_a,
    output logic             o_a_ovf
);
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_a_ovf;
    logic             r_b_ovf;
    logic [WIDTH:0]   w_sum;
    logic             w_ovf_next;
    logic [WIDTH-1:0] w_b_next;

    // Next b and its overflow; a_ovf implies b_ovf, so b_ovf|carry covers every overflow.
    always_comb begin
        w_sum      = {1'b0, r_a} + {1'b0, r_b};
        w_ovf_next = r_a_ovf | r_b_ovf | w_sum[WIDTH];
`ifdef FIB_CTRL_SAT_EN
        w_b_next   = w_ovf_next ? '1 : w_sum[WIDTH-1:0];
`else
        w_b_next   = w_sum[WIDTH-1:0];
`endif
    end

    // Pair register: reload to (0, 1) on reset or new request, advance one term per step.
    always_ff @(posedge clk) begin
        if (rst || i_load) begin
            r_a     <= '0;
            r_b     <= WIDTH'(1);
            r_a_ovf <= 1'b0;
            r_b_ovf <= 1'b0;
        end else if (i_step) begin
            r_a     <= r_b;
            r_b     <= w_b_next;
            r_a_ovf <= r_b_ovf;
            r_b_ovf <= w_ovf_next;
        end
    end

    assign o_a     = r_a;
    assign o_a_ovf = r_a_ovf;

endmodule

// File: rtl/fib_term_ctrl.sv
// Fibonacci term controller: accepts index N, steps the datapath N times and returns F(N)
// with an overflow flag. Optional macro FIB_CTRL_SAT_EN (in fib_step) saturates overflowed terms.
module fib_term_ctrl
    import fib_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned NW    = NW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fib_term_ctrl_if.slave bus
);
    logic [1:0]       r_state;
    logic [NW-1:0]    r_cnt;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_value;
    logic             r_resp_ovf;
    logic             w_load;
    logic             w_step;
    logic [WIDTH-1:0] w_a;
    logic             w_a_ovf;

    // Datapath controls; stepping is suppressed on abort since the run is being discarded.
    always_comb begin
        w_load = (r_state == ST_IDLE) && bus.req_valid;
        w_step = (r_state == ST_RUN) && (r_cnt != '0) && !bus.abort;
    end

    fib_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_load),
        .i_step  (w_step),
        .o_a     (w_a),
        .o_a_ovf (w_a_ovf)
    );

    // FSM, step counter and response registers; abort beats resp_ready in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_value <= '0;
            r_resp_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_cnt   <= bus.req_n;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        r_state <= ST_IDLE;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - NW'(1);
                    end else begin
                        r_resp_value <= w_a;
                        r_resp_ovf   <= w_a_ovf;
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.abort || bus.resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.busy       = (r_state == ST_RUN) || (r_state == ST_DONE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_value = r_resp_value;
    assign bus.resp_ovf   = r_resp_ovf;

endmodule
